// File: rtl/coderom_pkg.sv
// coderom_pkg: shared definitions for the code ROM arbiter.
//   - state_t  : access sequencer states
//   - BANK_W / WADDR_W / DATA_W : ROM geometry (4 x 8K x 16)
//   - bank_ce_n: bank number to active-low one-cold bank enable
package coderom_pkg;

  localparam int unsigned BANK_W  = 2;
  localparam int unsigned WADDR_W = 13;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned NBANK   = 1 << BANK_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } state_t;

  function automatic logic [NBANK-1:0] bank_ce_n(input logic [BANK_W-1:0] bank);
    logic [NBANK-1:0] ce;
    ce       = '1;
    ce[bank] = 1'b0;
    return ce;
  endfunction

endpackage

// File: rtl/coderom_sum.sv
// coderom_sum: 16-bit modulo checksum of DBG read data.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear, wins over a coincident add
//   add          : accumulate din at this edge
//   din          : data being completed to the DBG port
//   sum          : running checksum
module coderom_sum
  import coderom_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + din;
    end
  end

endmodule

// File: rtl/coderom_arb.sv
// coderom_arb: two-port arbiter and access sequencer for the code ROM.
// Each access runs IDLE -> ISSUE -> CAPTURE -> DONE (ack) -> IDLE.
//   clk, reset_n          : clock, asynchronous active-low reset
//   cpu_req/addr/ack/data : 68000 fetch port (addr = {bank, word})
//   dbg_req/addr/ack/data : debug / self-test read port
//   rom_a, rom_ce_n, rom_q: ROM word address, active-low bank enables, data
//   busy                  : sequencer not in IDLE
//   sum_clr, sum          : DBG checksum, present when CODEROM_SUM_EN is defined
// Parameter STARVE_MAX: CPU grants allowed while DBG waits before DBG is forced.
module coderom_arb
  import coderom_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cpu_req,
  input  logic [BANK_W+WADDR_W-1:0] cpu_addr,
  output logic                      cpu_ack,
  output logic [DATA_W-1:0]         cpu_data,
  input  logic                      dbg_req,
  input  logic [BANK_W+WADDR_W-1:0] dbg_addr,
  output logic                      dbg_ack,
  output logic [DATA_W-1:0]         dbg_data,
  output logic [WADDR_W-1:0]        rom_a,
  output logic [NBANK-1:0]          rom_ce_n,
  input  logic [DATA_W-1:0]         rom_q,
  output logic                      busy,
  input  logic                      sum_clr,
  output logic [DATA_W-1:0]         sum
);

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t                    state_q, state_d;
  logic                      owner_dbg_q;
  logic [2:0]                starve_q;
  logic                      any_req, grant_dbg;
  logic [BANK_W+WADDR_W-1:0] sel_addr;
  logic [WADDR_W-1:0]        rom_a_d;
  logic [NBANK-1:0]          ce_d;
  logic                      busy_d, cpu_ack_d, dbg_ack_d;

  assign any_req   = cpu_req | dbg_req;
  assign grant_dbg = ~cpu_req | (starve_q == SMAX);
  assign sel_addr  = grant_dbg ? dbg_addr : cpu_addr;

  // State and registered outputs. rom_a / rom_ce_n double as the latched
  // address and bank, so no separate address register is kept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_dbg_q <= 1'b0;
      rom_a       <= '0;
      rom_ce_n    <= '1;
      busy        <= 1'b0;
      cpu_ack     <= 1'b0;
      dbg_ack     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rom_a    <= rom_a_d;
      rom_ce_n <= ce_d;
      busy     <= busy_d;
      cpu_ack  <= cpu_ack_d;
      dbg_ack  <= dbg_ack_d;
      if (state_q == IDLE && any_req) begin
        owner_dbg_q <= grant_dbg;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed on the state being entered.
  always_comb begin
    rom_a_d   = rom_a;
    ce_d      = '1;
    case (state_d)
      ISSUE: begin
        rom_a_d = sel_addr[WADDR_W-1:0];
        ce_d    = bank_ce_n(sel_addr[BANK_W+WADDR_W-1:WADDR_W]);
      end
      CAPTURE: ce_d = rom_ce_n;
      default: ;
    endcase
    busy_d    = (state_d != IDLE);
    cpu_ack_d = (state_d == DONE) & ~owner_dbg_q;
    dbg_ack_d = (state_d == DONE) &  owner_dbg_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (!dbg_req || (any_req && grant_dbg)) begin
        starve_q <= '0;
      end else if (starve_q != SMAX) begin
        starve_q <= starve_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_data <= '0;
      dbg_data <= '0;
    end else if (state_q == CAPTURE) begin
      if (owner_dbg_q) dbg_data <= rom_q;
      else             cpu_data <= rom_q;
    end
  end

`ifdef CODEROM_SUM_EN
  logic sum_add;
  assign sum_add = (state_q == CAPTURE) & owner_dbg_q;

  coderom_sum u_sum (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (sum_clr),
    .add     (sum_add),
    .din     (rom_q),
    .sum     (sum)
  );
`else
  logic unused_sum_clr;
  assign unused_sum_clr = sum_clr;
  assign sum            = '0;
`endif

endmodule

// File: tb/tb_coderom_arb.sv
module tb_coderom_arb;

  localparam int SMAX = 4;

  logic        clk, reset_n;
  logic        cpu_req, dbg_req, cpu_ack, dbg_ack, busy, sum_clr;
  logic [14:0] cpu_addr, dbg_addr;
  logic [15:0] cpu_data, dbg_data, rom_q, sum;
  logic [12:0] rom_a;
  logic [3:0]  rom_ce_n;

  int n_chk = 0;
  int n_fail = 0;

  coderom_arb #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .rom_a(rom_a), .rom_ce_n(rom_ce_n), .rom_q(rom_q),
    .busy(busy), .sum_clr(sum_clr), .sum(sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a few pinned words, everything else a simple formula.
  function automatic logic [15:0] rom_word(input logic [1:0] b, input logic [12:0] a);
    if (b == 2'd1 && a == 13'd5)      return 16'hBEEF;
    if (b == 2'd3 && a == 13'h1FFF)   return 16'h7E57;
    if (b == 2'd2 && a == 13'h0010)   return 16'hFFFF;
    if (b == 2'd2 && a == 13'h0011)   return 16'h0002;
    return {b, a, 1'b1} ^ 16'h3C5A;
  endfunction

  // Registered ROM: one-cycle latency, garbage unless exactly one bank is enabled.
  always @(posedge clk) begin
    case (rom_ce_n)
      4'b1110: rom_q <= rom_word(2'd0, rom_a);
      4'b1101: rom_q <= rom_word(2'd1, rom_a);
      4'b1011: rom_q <= rom_word(2'd2, rom_a);
      4'b0111: rom_q <= rom_word(2'd3, rom_a);
      default: rom_q <= 16'hDEAD;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an access is a phase count 1..3 after the grant.
  int          m_phase, m_starve;
  bit          m_dbg;
  logic [1:0]  m_bank;
  logic [12:0] m_a;
  logic [15:0] m_cpu_data, m_dbg_data, m_sum;
  bit          m_win;
  assign m_win = !cpu_req || (m_starve == SMAX);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0; m_starve <= 0; m_dbg <= 0; m_bank <= 0; m_a <= 0;
      m_cpu_data <= 0; m_dbg_data <= 0; m_sum <= 0;
    end else begin
      if (m_phase == 0) begin
        m_starve <= (dbg_req && !m_win) ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
        if (cpu_req || dbg_req) begin
          m_phase <= 1;
          m_dbg   <= m_win;
          m_bank  <= m_win ? dbg_addr[14:13] : cpu_addr[14:13];
          m_a     <= m_win ? dbg_addr[12:0]  : cpu_addr[12:0];
        end
      end else begin
        m_phase <= (m_phase + 1) % 4;
      end
      if (m_phase == 2) begin
        if (m_dbg) m_dbg_data <= rom_word(m_bank, m_a);
        else       m_cpu_data <= rom_word(m_bank, m_a);
      end
`ifdef CODEROM_SUM_EN
      if (sum_clr) m_sum <= 0;
      else if (m_phase == 2 && m_dbg) m_sum <= m_sum + rom_word(m_bank, m_a);
`endif
    end
  end

  always @(negedge clk) begin
    logic [3:0] e;
    e = 4'hF;
    if (m_phase == 1 || m_phase == 2) e[m_bank] = 1'b0;
    chk("m_busy",     busy,     (m_phase != 0));
    chk("m_ce_n",     rom_ce_n, e);
    chk("m_cpu_ack",  cpu_ack,  (m_phase == 3 && !m_dbg));
    chk("m_dbg_ack",  dbg_ack,  (m_phase == 3 &&  m_dbg));
    chk("m_cpu_data", cpu_data, m_cpu_data);
    chk("m_dbg_data", dbg_data, m_dbg_data);
    chk("m_sum",      sum,      m_sum);
    if (m_phase == 1 || m_phase == 2) chk("m_rom_a", rom_a, m_a);
  end

  task automatic access(input bit is_dbg, input logic [14:0] addr, input bit clr_on_ack,
                        output int lat, output int lows, output logic [3:0] low_ce,
                        output logic [15:0] data);
    lat = -1; lows = 0; low_ce = 4'hF; data = '0;
    @(posedge clk); #1;
    if (is_dbg) begin dbg_addr = addr; dbg_req = 1'b1; end
    else        begin cpu_addr = addr; cpu_req = 1'b1; end
    for (int cyc = 0; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (rom_ce_n != 4'hF) begin lows++; low_ce = rom_ce_n; end
      if (is_dbg ? dbg_ack : cpu_ack) begin
        lat  = cyc;
        data = is_dbg ? dbg_data : cpu_data;
        if (clr_on_ack) sum_clr = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; dbg_req = 1'b0; sum_clr = 1'b0;
  endtask

  int          lat, lows, nacks, first_dbg, seq, cnt, ack_seen;
  logic [3:0]  low_ce;
  logic [15:0] data;
  logic [15:0] exp_sum;

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0; sum_clr = 1'b0;
    cpu_addr = '0; dbg_addr = '0;
    #22 reset_n = 1'b1;

    @(negedge clk);
    chk("rst_ce_n", rom_ce_n, 4'hF);
    chk("rst_rom_a", rom_a, 13'h0);
    chk("rst_acks", {cpu_ack, dbg_ack}, 2'b00);
    chk("rst_data", {cpu_data, dbg_data}, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", sum, 16'h0);

    // Single CPU read of bank 1 word 5.
    access(1'b0, 15'h2005, 1'b0, lat, lows, low_ce, data);
    chk("single_lat", lat, 3);
    chk("single_lows", lows, 2);
    chk("single_ce", low_ce, 4'b1101);
    chk("single_data", data, 16'hBEEF);

    // Simultaneous requests: CPU first, then DBG, exactly two acks.
    @(posedge clk); #1;
    cpu_addr = 15'h0000; dbg_addr = 15'h7FFF; cpu_req = 1'b1; dbg_req = 1'b1;
    nacks = 0; first_dbg = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) begin
        nacks++;
        if (first_dbg < 0) first_dbg = dbg_ack ? 1 : 0;
      end
      @(posedge clk); #1;
      if (cpu_ack) cpu_req = 1'b0;
      if (dbg_ack) dbg_req = 1'b0;
    end
    chk("simul_acks", nacks, 2);
    chk("simul_first_dbg", first_dbg, 0);
    chk("simul_cpu_data", cpu_data, 16'h3C5B);
    chk("simul_dbg_data", dbg_data, 16'h7E57);

    // Starvation: both held high; grant order C C C C D C C C C D.
    @(posedge clk); #1;
    cpu_addr = 15'h1234; dbg_addr = 15'h5678; cpu_req = 1'b1; dbg_req = 1'b1;
    seq = 0; cnt = 0;
    for (int cyc = 0; cyc < 80 && cnt < 10; cyc++) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) begin seq = (seq << 1) | (dbg_ack ? 1 : 0); cnt++; end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("starve_count", cnt, 10);
    chk("starve_order", seq, 32'h021);
    repeat (4) @(posedge clk);

    // Reset during CAPTURE.
    #1 cpu_addr = 15'h4ABC; cpu_req = 1'b1;
    lows = 0;
    for (int cyc = 0; cyc < 12 && lows < 2; cyc++) begin
      @(negedge clk);
      if (rom_ce_n != 4'hF) lows++;
    end
    chk("rst_mid_reach", lows, 2);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_ce_n", rom_ce_n, 4'hF);
    chk("rst_mid_acks", {cpu_ack, dbg_ack}, 2'b00);
    chk("rst_mid_busy", busy, 1'b0);
    cpu_req = 1'b0;
    @(negedge clk); #2 reset_n = 1'b1;
    ack_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) ack_seen++;
    end
    chk("rst_mid_no_ack", ack_seen, 0);

    // Checksum: FFFF + 0002 = 0001 when enabled, always 0 otherwise.
`ifdef CODEROM_SUM_EN
    exp_sum = 16'h0001;
`else
    exp_sum = 16'h0000;
`endif
    access(1'b1, 15'h4010, 1'b0, lat, lows, low_ce, data);
    chk("sum_rd1", data, 16'hFFFF);
    access(1'b1, 15'h4011, 1'b0, lat, lows, low_ce, data);
    chk("sum_rd2", data, 16'h0002);
    @(negedge clk);
    chk("sum_value", sum, exp_sum);
    access(1'b1, 15'h2005, 1'b1, lat, lows, low_ce, data);
    @(negedge clk);
    chk("sum_cleared", sum, 16'h0000);

    // Random traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (cpu_req) begin
        if (cpu_ack) begin
          if ($urandom_range(0, 2) == 0) cpu_addr = 15'($urandom);
          else cpu_req = 1'b0;
        end else if ($urandom_range(0, 60) == 0) cpu_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        cpu_addr = 15'($urandom); cpu_req = 1'b1;
      end
      if (dbg_req) begin
        if (dbg_ack) begin
          if ($urandom_range(0, 2) == 0) dbg_addr = 15'($urandom);
          else dbg_req = 1'b0;
        end else if ($urandom_range(0, 60) == 0) dbg_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        dbg_addr = 15'($urandom); dbg_req = 1'b1;
      end
      sum_clr = ($urandom_range(0, 24) == 0);
    end
    cpu_req = 1'b0; dbg_req = 1'b0; sum_clr = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
